// File: rtl/four_bit_dec_pkg.sv
// Shared constants and the 2-to-4 decode function for the select decoder.
package four_bit_dec_pkg;

    localparam int N_LINES   = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W_DEF = 8;

    // One-hot decode of a 2-bit select code. An unknown code yields all-X
    // so a bad select shows up in simulation instead of a plausible line.
    function automatic logic [N_LINES-1:0] dec2to4(input logic [SEL_W-1:0] sel);
        case (sel)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            2'b11:   return 4'b1000;
            default: return 'x;
        endcase
    endfunction

endpackage

// File: rtl/four_bit_dec_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold by default, step only when selected and not at max.
    always_comb begin
        // NOTE: assigning the hold value first means every path drives cnt_d, so no latch is inferred.
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values, independent of block order.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/four_bit_dec.sv
// 2-to-4 one-hot select decoder with registered copy, change pulse and
// per-line saturating usage counters.
module four_bit_dec
    import four_bit_dec_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         a,
    output logic [N_LINES-1:0]       y,
    output logic [N_LINES-1:0]       y_q,
    output logic                     a_chg,
    output logic [N_LINES*CNT_W-1:0] hit_cnt
);

    logic [N_LINES-1:0] y_reg_q,      y_reg_d;
    logic [SEL_W-1:0]   a_prev_q,     a_prev_d;
    logic               prev_valid_q, prev_valid_d;
    logic               a_chg_q,      a_chg_d;

    // Combinational decode, live regardless of clock or reset.
    assign y = dec2to4(a);

    // Next-state for the monitor registers; a change is only reported once
    // a previous sample exists.
    always_comb begin
        y_reg_d      = y;
        a_prev_d     = a;
        prev_valid_d = 1'b1;
        a_chg_d      = prev_valid_q && (a != a_prev_q);
    end

    // Monitor registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg_q      <= '0;
            a_prev_q     <= '0;
            prev_valid_q <= 1'b0;
            a_chg_q      <= 1'b0;
        end else begin
            y_reg_q      <= y_reg_d;
            a_prev_q     <= a_prev_d;
            prev_valid_q <= prev_valid_d;
            a_chg_q      <= a_chg_d;
        end
    end

    assign y_q   = y_reg_q;
    assign a_chg = a_chg_q;

    // One usage counter per select line, stepped by that line of the decode.
    for (genvar i = 0; i < N_LINES; i++) begin : g_cnt
        sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (y[i]),
            .cnt (hit_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_four_bit_dec.sv
// Self-checking bench for four_bit_dec: directed steps plus random traffic,
// compared against a behavioural model; two instances (8-bit and 3-bit counters).
module tb_four_bit_dec;

    localparam int W8 = 8;
    localparam int W3 = 3;

    logic                clk = 1'b0;
    logic                clk_en = 1'b0;
    logic                rst = 1'b0;
    logic [1:0]          a = 2'b00;

    logic [3:0]          y8, yq8, y3, yq3;
    logic                chg8, chg3;
    logic [4*W8-1:0]     hc8;
    logic [4*W3-1:0]     hc3;

    int                  errors = 0;
    int                  checks = 0;

    // Reference model state
    int unsigned         cnt8_m [4];
    int unsigned         cnt3_m [4];
    logic [3:0]          yq_m;
    logic                chg_m;
    logic [1:0]          prev_m;
    bit                  pv_m;

    four_bit_dec #(.CNT_W(W8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .y       (y8),
        .y_q     (yq8),
        .a_chg   (chg8),
        .hit_cnt (hc8)
    );

    four_bit_dec #(.CNT_W(W3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .y       (y3),
        .y_q     (yq3),
        .a_chg   (chg3),
        .hit_cnt (hc3)
    );

    always #5 clk = clk_en ? ~clk : clk;

    function automatic logic [3:0] onehot(input int unsigned k);
        return 4'(1 << k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [1:0] av, input logic rv);
        if (rv) begin
            yq_m   = 4'b0000;
            chg_m  = 1'b0;
            prev_m = 2'b00;
            pv_m   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt8_m[i] = 0;
                cnt3_m[i] = 0;
            end
        end else begin
            yq_m   = onehot(int'(av));
            chg_m  = pv_m && (av != prev_m);
            prev_m = av;
            pv_m   = 1'b1;
            if (cnt8_m[av] < (2**W8 - 1)) cnt8_m[av]++;
            if (cnt3_m[av] < (2**W3 - 1)) cnt3_m[av]++;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [4*W8-1:0] e8;
        logic [4*W3-1:0] e3;
        for (int i = 0; i < 4; i++) begin
            e8[i*W8 +: W8] = W8'(cnt8_m[i]);
            e3[i*W3 +: W3] = W3'(cnt3_m[i]);
        end
        check({tag, ".y_q8"},  {28'b0, yq8},  {28'b0, yq_m});
        check({tag, ".chg8"},  {31'b0, chg8}, {31'b0, chg_m});
        check({tag, ".hc8"},   hc8,           e8);
        check({tag, ".y_q3"},  {28'b0, yq3},  {28'b0, yq_m});
        check({tag, ".chg3"},  {31'b0, chg3}, {31'b0, chg_m});
        check({tag, ".hc3"},   {20'b0, hc3},  {20'b0, e3});
        check({tag, ".y"},     {28'b0, y8},   {28'b0, onehot(int'(a))});
    endtask

    // Drive inputs just after a falling edge, take one rising edge, compare at the next falling edge.
    task automatic step(input logic [1:0] av, input logic rv, input string tag);
        a   = av;
        rst = rv;
        @(posedge clk);
        model_edge(av, rv);
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        logic [1:0] ax;

        // Combinational sweep with the clock idle, then with reset held.
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            #1;
            check("idle.y8", {28'b0, y8}, {28'b0, onehot(i)});
            check("idle.y3", {28'b0, y3}, {28'b0, onehot(i)});
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            #1;
            check("rst.y8", {28'b0, y8}, {28'b0, onehot(i)});
        end

        // Start the clock and reset.
        clk_en = 1'b1;
        @(negedge clk);
        step(2'd0, 1'b1, "reset");

        // First sample after reset.
        step(2'd2, 1'b0, "first");
        check("first.y_q",  {28'b0, yq8},  32'h0000_0004);
        check("first.chg",  {31'b0, chg8}, 32'h0);
        check("first.hc",   hc8,           32'h0001_0000);

        // Sequence 1,1,3 after reset.
        step(2'd0, 1'b1, "rst2");
        step(2'd1, 1'b0, "seq1");
        check("seq1.chg", {31'b0, chg8}, 32'h0);
        step(2'd1, 1'b0, "seq2");
        check("seq2.chg", {31'b0, chg8}, 32'h0);
        step(2'd3, 1'b0, "seq3");
        check("seq3.chg", {31'b0, chg8}, 32'h1);
        check("seq3.hc",  hc8,           32'h0100_0200);

        // Saturation of the 3-bit counters: hold a=0 for 10 edges.
        step(2'd0, 1'b1, "rst3");
        for (int i = 0; i < 10; i++) step(2'd0, 1'b0, "hold0");
        check("sat3.line0", {29'b0, hc3[2:0]}, 32'd7);
        check("sat3.line0_w8", {24'b0, hc8[7:0]}, 32'd10);

        // Saturation of an 8-bit counter.
        for (int i = 0; i < 260; i++) step(2'd1, 1'b0, "hold1");
        check("sat8.line1", {24'b0, hc8[15:8]}, 32'd255);

        // Reset mid-operation with counters nonzero.
        step(2'd3, 1'b1, "midrst");
        check("midrst.hc8", hc8, 32'h0);
        check("midrst.y",   {28'b0, y8}, 32'h8);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0), "rand");
        end

        // Unknown select must not decode to a valid line.
        step(2'd0, 1'b1, "rst4");
        a = 2'bx0;
        #1;
        ax = a;
        if ($isunknown(ax)) begin
            check("xsel.y", {28'b0, y8}, {28'b0, 4'bxxxx});
        end else begin
            check("xsel.y", {28'b0, y8}, {28'b0, onehot(int'(ax))});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
